apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB4 completer (slave) holding a 32-entry x 32-bit register file, addressed by a 5-bit word index.
- Sits on the peripheral bus behind the APB requester (master). Supports byte-strobed writes, reads, a read-only ID register and a privileged register region.
- Flags illegal accesses with pslverr.

Parameters:
- ID_VALUE, 32'hA9B0_0001, constant returned by register 0 (read-only).
- PRIV_BASE, 24, first word index of the privileged region; indices PRIV_BASE..31 require a privileged access.
- WAIT_CYCLES, 2, number of wait states inserted per transfer; used only when APB_WAIT_STATES_EN is defined.

Ports:
- clk  input  1  bus clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pwrite  input  1  1 = write, 0 = read.
- addr  input  5  word index 0..31.
- psel  input  1  completer select.
- penable  input  1  access-phase indicator.
- pstrobe  input  4  byte-lane write strobes; bit n enables pwdata[8n+7:8n].
- prot  input  3  protection: [0] privileged, [1] non-secure, [2] instruction (only [0] is decoded).
- pwdata  input  32  write data.
- pready  output  1  transfer-complete indication.
- pslverr  output  1  error response; valid only while pready=1.
- prdata  output  32  read data; valid only while pready=1 on a read.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset: all registers 1..31 cleared to 0, FSM to IDLE, wait counter 0.
- While in reset: pready=0, pslverr=0, prdata=0.
- Reset asserted mid-transfer aborts the transfer with no register write, and pready drops immediately.
- FSM states:
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> ACCESS on the next edge (penable is expected to be 1).
  - ACCESS stays while pready=0.
  - On completion (pready=1): ACCESS -> SETUP if psel=1 and penable=0 (back-to-back transfer), else -> IDLE.
  - psel dropping in SETUP or ACCESS returns to IDLE with no write.
  - penable=1 in IDLE (no setup phase) is ignored: no pready, no write.
- pready: combinational, high only in ACCESS with psel=penable=1 and the wait count satisfied. Zero wait states in the default build.
- Error decode, evaluated from addr/pwrite/prot in the access phase:
  - ERR_RO: write to index 0.
  - ERR_PRIV: addr >= PRIV_BASE with prot[0]=0.
  - pslverr = pready & (ERR_RO | ERR_PRIV); otherwise 0.
- Write: commits on the clk edge where psel & penable & pwrite & pready & no error.
  - Only lanes with pstrobe[n]=1 update; other bytes are retained.
  - pstrobe=0 completes normally without changing the register.
- Read: prdata = ID_VALUE for index 0, register contents otherwise. Combinational while pready & ~pwrite & no error.
  - On an erroring read, on writes, and outside the access phase, prdata=0.
  - pstrobe is ignored on reads.
- Address, data, strobe and prot are sampled only during ACCESS; changes during SETUP are tolerated.
- A write followed by a read of the same index returns the new value; there is no extra latency.

Optional Feature:
- APB_WAIT_STATES_EN:
  - When defined: an internal counter clears on entry to ACCESS and increments each ACCESS cycle. pready stays 0 until the counter equals WAIT_CYCLES, so a transfer takes 2+WAIT_CYCLES cycles.
  - Errors and writes take effect only on the completing cycle.
  - Reset or psel drop clears the counter.
- When undefined: the counter logic is absent and every transfer takes 2 cycles (zero wait states).

Decomposition:
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS); localparams for data width 32, address width 5, register depth 32; default ID_VALUE; prot bit positions.
- One natural sub-module: apb_regfile_bank, the 32x32 storage with byte-strobe write port and combinational read port.
- FSM, error decode and wait logic stay in the top module.

Test Plan:
- Reset: assert reset mid-ACCESS -> pready=0, prdata=0 immediately. After release, a read of index 5 returns 32'h0 and a read of index 0 returns 32'hA9B0_0001.
- Write/read: write index 3 = 32'hDEAD_BEEF, pstrobe=4'hF, prot=3'b001 -> pready=1 in the 2nd cycle, pslverr=0. A read of index 3 returns 32'hDEAD_BEEF.
- Strobes: index 3 holds 32'hDEAD_BEEF; write 32'h1122_3344 with pstrobe=4'b0101 -> a read returns 32'hDE22_BE44.
- Read-only: write 32'hFFFF_FFFF to index 0 -> pslverr=1 with pready. A read of index 0 still returns 32'hA9B0_0001.
- Privilege:
  - Write index 26 with prot=3'b000 -> pslverr=1 and no update; a read with prot=3'b001 returns 0.
  - The same write with prot=3'b001 succeeds.
  - An unprivileged read of index 26 -> pslverr=1, prdata=0.
- Protocol and wait states:
  - penable=1 without a setup phase -> no pready.
  - Back-to-back transfers complete every 2 cycles.
  - With APB_WAIT_STATES_EN and WAIT_CYCLES=2, pready rises in the 4th cycle of each transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 register-file completer.
//   - Bus geometry: 32-bit data, 5-bit word index, 32 registers, 4 byte lanes.
//   - Default contents of the read-only ID register.
//   - Bit positions inside the APB prot bus.
//   - Transfer phase enumeration used by the completer FSM.
package apb_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = 5;
  localparam int unsigned RegDepth  = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  localparam logic [DataWidth-1:0] IdValueDefault = 32'hA9B0_0001;

  localparam int unsigned ProtPrivBit  = 0;
  localparam int unsigned ProtNsBit    = 1;
  localparam int unsigned ProtInstrBit = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

endpackage

// File: rtl/apb_regfile_bank.sv
// 32 x 32-bit register storage with a byte-strobed write port and an
// asynchronous (combinational) read port.
// Ports:
//   clk    in   clock, writes on rising edge
//   reset  in   asynchronous active-high reset, clears every entry
//   we     in   write enable for this cycle
//   waddr  in   write word index
//   wstrb  in   byte-lane enables; lane n covers wdata[8n+7:8n]
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  contents of entry raddr
module apb_regfile_bank
  import apb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [StrbWidth-1:0] wstrb,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem_q [RegDepth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RegDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      // Lanes with a clear strobe keep their previous byte.
      for (int b = 0; b < StrbWidth; b++) begin
        if (wstrb[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer in front of a 32 x 32-bit register file.
//   - Index 0 is a read-only ID register returning ID_VALUE.
//   - Indices PRIV_BASE..31 need prot[0]=1 (privileged access).
//   - Illegal accesses complete with pslverr=1, no write and prdata=0.
// Optional build macro APB_WAIT_STATES_EN: inserts WAIT_CYCLES wait states
// into every transfer (the WAIT_CYCLES parameter exists only in that build).
// Ports:
//   clk      in   bus clock
//   reset    in   asynchronous active-high reset
//   pwrite   in   1 = write, 0 = read
//   addr     in   5-bit word index
//   psel     in   completer select
//   penable  in   access-phase indicator
//   pstrobe  in   byte-lane write strobes
//   prot     in   protection; only prot[0] (privileged) is decoded
//   pwdata   in   write data
//   pready   out  transfer complete (combinational)
//   pslverr  out  error response, qualified by pready
//   prdata   out  read data, qualified by pready on error-free reads
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter logic [DataWidth-1:0] ID_VALUE  = IdValueDefault,
  parameter int unsigned          PRIV_BASE = 24
`ifdef APB_WAIT_STATES_EN
  ,
  parameter int unsigned          WAIT_CYCLES = 2
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwrite,
  input  logic [AddrWidth-1:0] addr,
  input  logic                 psel,
  input  logic                 penable,
  input  logic [StrbWidth-1:0] pstrobe,
  input  logic [2:0]           prot,
  input  logic [DataWidth-1:0] pwdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic [DataWidth-1:0] prdata
);

  apb_state_e           state_q, state_d;
  apb_state_e           phase;
  logic                 wait_done;
  logic                 err_ro, err_priv, err;
  logic                 bank_we;
  logic [DataWidth-1:0] bank_rdata;

  // Only the privileged bit is decoded.
  logic unused_prot;
  assign unused_prot = prot[ProtNsBit] ^ prot[ProtInstrBit];

  // The setup phase is recognised from the bus in the same cycle it occurs,
  // so the register only needs to remember that the next cycle is ACCESS.
  // This keeps single and back-to-back transfers at two cycles each.
  always_comb begin
    phase = state_q;
    if (state_q == StIdle && psel && !penable) begin
      phase = StSetup;
    end
  end

  always_comb begin
    state_d = StIdle;
    case (phase)
      StSetup: begin
        state_d = psel ? StAccess : StIdle;
      end
      StAccess: begin
        // A following setup phase is picked up again from IDLE.
        if (!psel || pready) begin
          state_d = StIdle;
        end else begin
          state_d = StAccess;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef APB_WAIT_STATES_EN
  localparam logic [7:0] WaitTarget = 8'(WAIT_CYCLES);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (phase == StSetup || !psel) begin
      wait_cnt_d = '0;
    end else if (phase == StAccess && wait_cnt_q != WaitTarget) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_done = (wait_cnt_q == WaitTarget);
`else
  assign wait_done = 1'b1;
`endif

  assign pready = !reset && (state_q == StAccess) && psel && penable && wait_done;

  assign err_ro   = pwrite && (addr == '0);
  assign err_priv = (32'(addr) >= PRIV_BASE) && !prot[ProtPrivBit];
  assign err      = err_ro || err_priv;

  assign pslverr = pready && err;
  assign bank_we = pready && pwrite && !err;

  always_comb begin
    prdata = '0;
    if (pready && !pwrite && !err) begin
      prdata = (addr == '0) ? ID_VALUE : bank_rdata;
    end
  end

  apb_regfile_bank u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (bank_we),
    .waddr (addr),
    .wstrb (pstrobe),
    .wdata (pwdata),
    .raddr (addr),
    .rdata (bank_rdata)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: a directed vector table, a few
// hand-written protocol sequences and randomized transfers compared against
// an array-based reference model.
module tb_apb_slave_regfile;

  localparam logic [31:0] IdVal    = 32'hA9B0_0001;
  localparam int          PrivBase = 24;
`ifdef APB_WAIT_STATES_EN
  localparam int          ExpCycles = 4;
`else
  localparam int          ExpCycles = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pwrite;
  logic [4:0]  addr;
  logic        psel;
  logic        penable;
  logic [3:0]  pstrobe;
  logic [2:0]  prot;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] model [32];

  apb_slave_regfile dut (
    .clk     (clk),
    .reset   (reset),
    .pwrite  (pwrite),
    .addr    (addr),
    .psel    (psel),
    .penable (penable),
    .pstrobe (pstrobe),
    .prot    (prot),
    .pwdata  (pwdata),
    .pready  (pready),
    .pslverr (pslverr),
    .prdata  (prdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        wr;
    bit [4:0]  a;
    bit [31:0] d;
    bit [3:0]  s;
    bit [2:0]  p;
    bit        e;
    bit [31:0] r;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access rules stated directly.
  function automatic bit ref_err(input bit wr, input bit [4:0] a, input bit [2:0] p);
    return (wr && a == 5'd0) || (int'(a) >= PrivBase && !p[0]);
  endfunction

  function automatic bit [31:0] ref_read(input bit wr, input bit [4:0] a, input bit [2:0] p);
    if (wr || ref_err(wr, a, p)) return 32'h0;
    if (a == 5'd0) return IdVal;
    return model[a];
  endfunction

  task automatic ref_apply(input bit wr, input bit [4:0] a, input bit [31:0] d,
                           input bit [3:0] s, input bit [2:0] p);
    if (wr && !ref_err(wr, a, p)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic idle();
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1; ends at posedge+1 after the completing edge with psel still high.
  task automatic xfer(input bit wr, input bit [4:0] a, input bit [31:0] d, input bit [3:0] s,
                      input bit [2:0] p, input bit scramble,
                      output bit err, output bit [31:0] rd, output int cyc);
    psel    = 1'b1;
    penable = 1'b0;
    if (scramble) begin
      pwrite  = 1'($urandom);
      addr    = 5'($urandom);
      pwdata  = $urandom;
      pstrobe = 4'($urandom);
      prot    = 3'($urandom);
    end else begin
      pwrite  = wr;
      addr    = a;
      pwdata  = d;
      pstrobe = s;
      prot    = p;
    end
    @(negedge clk);
    check("setup_pready", 32'(pready), 32'h0);
    check("setup_prdata", prdata, 32'h0);
    @(posedge clk);
    #1;
    penable = 1'b1;
    pwrite  = wr;
    addr    = a;
    pwdata  = d;
    pstrobe = s;
    prot    = p;
    cyc = 2;
    @(negedge clk);
    while (!pready && cyc < 16) begin
      check("wait_pslverr", 32'(pslverr), 32'h0);
      @(posedge clk);
      #1;
      cyc++;
      @(negedge clk);
    end
    if (!pready) check("ready_timeout", 32'(pready), 32'h1);
    err = pslverr;
    rd  = prdata;
    @(posedge clk);
    #1;
  endtask

  task automatic run_check(input string tag, input bit wr, input bit [4:0] a,
                           input bit [31:0] d, input bit [3:0] s, input bit [2:0] p,
                           input bit scramble, input bit exp_err, input bit [31:0] exp_rd);
    bit        err;
    bit [31:0] rd;
    int        cyc;
    xfer(wr, a, d, s, p, scramble, err, rd, cyc);
    check($sformatf("%s_pslverr", tag), 32'(err), 32'(exp_err));
    check($sformatf("%s_prdata", tag), rd, exp_rd);
    check($sformatf("%s_cycles", tag), 32'(cyc), 32'(ExpCycles));
    ref_apply(wr, a, d, s, p);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 5'd5,  32'h0,         4'hF,    3'b001, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,         4'hF,    3'b000, 1'b0, IdVal};
    tbl[2]  = '{1'b1, 5'd3,  32'hDEAD_BEEF, 4'hF,    3'b001, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 5'd3,  32'h0,         4'h0,    3'b001, 1'b0, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b1, 5'd3,  32'h1122_3344, 4'b0101, 3'b001, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 5'd3,  32'h0,         4'hF,    3'b001, 1'b0, 32'hDE22_BE44};
    tbl[6]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 4'hF,    3'b001, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,         4'hF,    3'b001, 1'b0, IdVal};
    tbl[8]  = '{1'b1, 5'd26, 32'h1234_5678, 4'hF,    3'b000, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 5'd26, 32'h0,         4'hF,    3'b001, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 5'd26, 32'h1234_5678, 4'hF,    3'b001, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 5'd26, 32'h0,         4'hF,    3'b001, 1'b0, 32'h1234_5678};
    tbl[12] = '{1'b0, 5'd26, 32'h0,         4'hF,    3'b000, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 5'd3,  32'hFFFF_FFFF, 4'h0,    3'b001, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 5'd3,  32'h0,         4'hA,    3'b110, 1'b0, 32'hDE22_BE44};
    tbl[15] = '{1'b1, 5'd0,  32'h0,         4'hF,    3'b000, 1'b1, 32'h0};
    tbl[16] = '{1'b0, 5'd31, 32'h0,         4'hF,    3'b001, 1'b0, 32'h0};
    tbl[17] = '{1'b1, 5'd23, 32'hAABB_CCDD, 4'hF,    3'b000, 1'b0, 32'h0};
    tbl[18] = '{1'b0, 5'd23, 32'h0,         4'hF,    3'b000, 1'b0, 32'hAABB_CCDD};

    ref_clear();
    reset   = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    addr    = 5'd0;
    pstrobe = 4'h0;
    prot    = 3'b000;
    pwdata  = 32'h0;
    #1;
    check("inrst_pready", 32'(pready), 32'h0);
    check("inrst_pslverr", 32'(pslverr), 32'h0);
    check("inrst_prdata", prdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      run_check($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].p,
                1'b0, tbl[i].e, tbl[i].r);
      idle();
    end

    // Reset asserted in the middle of the access phase
    run_check("pre_rst_wr5", 1'b1, 5'd5, 32'h0000_0055, 4'hF, 3'b001, 1'b0, 1'b0, 32'h0);
    idle();
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    addr    = 5'd5;
    prot    = 3'b001;
    @(posedge clk);
    #1;
    penable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_pready", 32'(pready), 32'h0);
    check("midrst_prdata", prdata, 32'h0);
    check("midrst_pslverr", 32'(pslverr), 32'h0);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    ref_clear();
    @(posedge clk);
    #1;
    run_check("post_rst_rd5", 1'b0, 5'd5, 32'h0, 4'hF, 3'b001, 1'b0, 1'b0, 32'h0);
    idle();
    run_check("post_rst_rd0", 1'b0, 5'd0, 32'h0, 4'hF, 3'b001, 1'b0, 1'b0, IdVal);
    idle();

    // penable without a setup phase is ignored
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    addr    = 5'd7;
    pwdata  = 32'hFFFF_FFFF;
    pstrobe = 4'hF;
    prot    = 3'b001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("nosetup_pready", 32'(pready), 32'h0);
      @(posedge clk);
      #1;
    end
    idle();
    run_check("nosetup_rd7", 1'b0, 5'd7, 32'h0, 4'hF, 3'b001, 1'b0, 1'b0, 32'h0);
    idle();

    // Back-to-back: write then immediate read of the same index
    run_check("b2b_wr9", 1'b1, 5'd9, 32'hCAFE_F00D, 4'hF, 3'b001, 1'b0, 1'b0, 32'h0);
    run_check("b2b_rd9", 1'b0, 5'd9, 32'h0, 4'hF, 3'b001, 1'b0, 1'b0, 32'hCAFE_F00D);
    run_check("b2b_wr9b", 1'b1, 5'd9, 32'h0000_00AA, 4'b0001, 3'b001, 1'b0, 1'b0, 32'h0);
    run_check("b2b_rd9b", 1'b0, 5'd9, 32'h0, 4'hF, 3'b001, 1'b0, 1'b0, 32'hCAFE_F0AA);
    idle();

    // Randomized transfers against the reference model
    for (int n = 0; n < 200; n++) begin
      bit        wr;
      bit [4:0]  a;
      bit [31:0] d;
      bit [3:0]  s;
      bit [2:0]  p;
      wr = 1'($urandom);
      a  = 5'($urandom);
      d  = $urandom;
      s  = 4'($urandom);
      p  = 3'($urandom);
      run_check($sformatf("rnd%0d", n), wr, a, d, s, p, 1'($urandom),
                ref_err(wr, a, p), ref_read(wr, a, p));
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    // Final sweep of every register against the model
    for (int i = 0; i < 32; i++) begin
      run_check($sformatf("sweep%0d", i), 1'b0, 5'(i), 32'h0, 4'hF, 3'b001, 1'b0, 1'b0,
                ref_read(1'b0, 5'(i), 3'b001));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
